// File: rtl/alu_shift_seq_if.sv
// alu_shift_seq_if: request/result bundle between a requester and the sliced shifter
interface alu_shift_seq_if #(parameter int WIDTH = 8);
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] op;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    modport master (output start, mode, op, cin, input busy, done, result, cout, zero);
    modport slave  (input start, mode, op, cin, output busy, done, result, cout, zero);
endinterface

// File: rtl/alu_shift_seq.sv
// alu_shift_seq: rotate/shift/swap unit producing SLICE result bits per clock
module alu_shift_seq #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input logic            clk,
    input logic            reset,
    alu_shift_seq_if.slave bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_q, full, res_q;
    logic [2:0]       mode_q;
    logic             cin_q, left, lsb_in, msb_in, full_cout, nz_acc, cout_q, zero_q, last, accept;
    logic [CW-1:0]    cnt;
    logic [SLICE-1:0] slice;
    assign last   = cnt == CW'(N - 1);
    assign accept = state == IDLE && bus.start;
    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    // next state: one RUN cycle per slice, then a single FIN cycle carrying done
    always_comb begin
        state_nxt = state;
        state_nxt = accept                   ? RUN  :
                    (state == RUN && last)   ? FIN  :
                    (state == FIN)           ? IDLE : state;
    end
    // reference word built only from the latched operand; the current slice is picked from it
    always_comb begin
        left      = ~mode_q[0] && mode_q != 3'd6;
        lsb_in    = mode_q == 3'd0 ? op_q[WIDTH-1] : mode_q == 3'd2 ? cin_q : 1'b0;
        msb_in    = mode_q == 3'd1 ? op_q[0] : mode_q == 3'd3 ? cin_q :
                    mode_q == 3'd5 ? op_q[WIDTH-1] : 1'b0;
        full      = mode_q == 3'd6 ? {op_q[WIDTH/2-1:0], op_q[WIDTH-1:WIDTH/2]} :
                    left           ? {op_q[WIDTH-2:0], lsb_in} : {msb_in, op_q[WIDTH-1:1]};
        full_cout = mode_q == 3'd6 ? 1'b0 : left ? op_q[WIDTH-1] : op_q[0];
        slice     = full[int'(cnt)*SLICE +: SLICE];
    end
    // operand capture, slice write-back and flag accumulation; flags finalise on the last slice
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            op_q   <= '0;
            mode_q <= '0;
            cin_q  <= 1'b0;
            cnt    <= '0;
            nz_acc <= 1'b0;
            res_q  <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (accept) begin
            op_q   <= bus.op;
            mode_q <= bus.mode;
            cin_q  <= bus.cin;
            cnt    <= '0;
            nz_acc <= 1'b0;
            res_q  <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (state == RUN) begin
            res_q[int'(cnt)*SLICE +: SLICE] <= slice;
            cnt    <= last ? '0 : cnt + 1'b1;
            nz_acc <= nz_acc | (|slice);
            if (last) begin
                cout_q <= full_cout;
                zero_q <= ~(nz_acc | (|slice));
            end
        end
    assign bus.busy   = state == RUN;
    assign bus.done   = state == FIN;
    assign bus.result = res_q;
    assign bus.cout   = cout_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_alu_shift_seq.sv
// tb_alu_shift_seq: random and directed checks of alu_shift_seq against an arithmetic model
module tb_alu_shift_seq;
    localparam int W = 8;
    localparam int S = 4;
    localparam int N = W / S;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    alu_shift_seq_if #(.WIDTH(W)) bus ();
    alu_shift_seq #(.WIDTH(W), .SLICE(S)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // returns {cout, zero, result}
    function automatic logic [W+1:0] model(input logic [2:0] m, input logic [W-1:0] a, input logic c);
        logic [W-1:0] r;
        logic co;
        case (m)
            3'd0: begin r = (a << 1) | (a >> (W - 1)); co = a[W-1]; end
            3'd1: begin r = (a >> 1) | (a << (W - 1)); co = a[0]; end
            3'd2: begin r = (a << 1) | W'(c); co = a[W-1]; end
            3'd3: begin r = a >> 1; r[W-1] = c; co = a[0]; end
            3'd4: begin r = a << 1; co = a[W-1]; end
            3'd5: begin r = W'($signed(a) >>> 1); co = a[0]; end
            3'd6: begin r = (a << (W / 2)) | (a >> (W / 2)); co = 1'b0; end
            default: begin r = a >> 1; co = a[0]; end
        endcase
        return {co, r == '0, r};
    endfunction
    task automatic run_op(input logic [2:0] m, input logic [W-1:0] a, input logic c, input logic [W-1:0] post);
        logic [W+1:0] e;
        e = model(m, a, c);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.op = a; bus.cin = c;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.op = post; bus.cin = ~c; bus.mode = 3'($urandom);
        for (int k = 1; k <= N + 1; k++) begin
            @(negedge clk);
            if (k <= N) begin
                check($sformatf("busy m%0d k%0d", m, k), {31'd0, bus.busy}, 32'd1);
                check($sformatf("nodone m%0d k%0d", m, k), {31'd0, bus.done}, 32'd0);
            end else begin
                check($sformatf("done m%0d", m), {31'd0, bus.done}, 32'd1);
                check($sformatf("result m%0d op%0h", m, a), 32'(bus.result), 32'(e[W-1:0]));
                check($sformatf("cout m%0d op%0h", m, a), {31'd0, bus.cout}, {31'd0, e[W+1]});
                check($sformatf("zero m%0d op%0h", m, a), {31'd0, bus.zero}, {31'd0, e[W]});
            end
            bus.start = 1'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("done one cycle", {31'd0, bus.done}, 32'd0);
        check("result hold", 32'(bus.result), 32'(e[W-1:0]));
    endtask
    initial begin
        int dones, last_k;
        logic seen;
        bus.start = 1'b0; bus.mode = '0; bus.op = '0; bus.cin = 1'b0;
        #2;
        check("reset outs", {26'd0, bus.busy, bus.done, bus.cout, bus.zero, 2'd0} | 32'(bus.result), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(3'd7, 8'hA5, 1'b0, 8'h00);
        run_op(3'd5, 8'h81, 1'b0, 8'h11);
        run_op(3'd0, 8'h85, 1'b0, 8'h22);
        run_op(3'd2, 8'h80, 1'b0, 8'h7F);
        run_op(3'd3, 8'h01, 1'b1, 8'hFE);
        run_op(3'd6, 8'h3C, 1'b0, 8'hFF);
        run_op(3'd4, 8'h00, 1'b1, 8'hFF);
        // continuous start: one op per N+2 cycles
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 3'd7; bus.op = 8'h02; bus.cin = 1'b0;
        dones = 0; last_k = -1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                check("b2b result", 32'(bus.result), 32'h01);
                if (last_k >= 0) check("b2b gap", 32'(k - last_k), 32'(N + 2));
                last_k = k;
            end
        end
        check("b2b count", 32'(dones), 32'd4);
        bus.start = 1'b0;
        repeat (N + 3) @(negedge clk);
        // reset mid-run aborts with no done
        bus.start = 1'b1; bus.mode = 3'd4; bus.op = 8'hFF;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check("abort outs", {26'd0, bus.busy, bus.done, bus.cout, bus.zero, 2'd0} | 32'(bus.result), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (N + 3) begin
            @(negedge clk);
            seen |= bus.done;
        end
        check("abort no done", {31'd0, seen}, 32'd0);
        run_op(3'd4, 8'hFF, 1'b0, 8'h00);
        for (int i = 0; i < 150; i++)
            run_op(3'($urandom), W'($urandom), 1'($urandom), W'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
